// File: rtl/fpu_result_uart_tx_if.sv
// Result-word handshake between the FPU and the UART result streamer.
interface fpu_result_uart_tx_if;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;

  modport master (output res_valid, output res_data, input res_ready);
  modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/fpu_result_uart_tx.sv
// Buffers 32-bit FPU results in a small FIFO and streams each word as four
// back-to-back 8N1 UART frames, least significant byte first.
module fpu_result_uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          clks_per_bit,
  fpu_result_uart_tx_if.slave  res,
  output logic                 o_tx_serial,
  output logic                 o_tx_active,
  output logic                 o_tx_done,
  output logic [4:0]           o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         r_state, w_state_nxt;
  logic [31:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [4:0]     r_count;
  logic [31:0]    r_word;
  logic [15:0]    r_cpb;
  logic [15:0]    r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]     r_bit_idx, w_bit_nxt;
  logic [1:0]     r_byte_idx, w_byte_nxt;
  logic           r_tx_serial, w_serial_nxt;
  logic           r_tx_done, w_done_nxt;
  logic           w_ready, w_push, w_pop, w_bit_end;

  assign w_ready       = (r_count < 5'(FIFO_DEPTH));
  assign res.res_ready = w_ready;
  assign w_pop         = (r_state == IDLE) && (r_count != 5'd0);
  // A word offered while full still lands if the head is leaving this cycle.
  assign w_push        = res.res_valid && (w_ready || w_pop);
  assign w_bit_end     = (r_clk_cnt == r_cpb - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst && w_push)
      r_mem[r_wr_ptr] <= res.res_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_nxt     = r_bit_idx;
    w_byte_nxt    = r_byte_idx;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clk_cnt_nxt = 16'd0;
        w_bit_nxt     = 3'd0;
        w_byte_nxt    = 2'd0;
        if (w_pop) w_state_nxt = START;
      end
      START: begin
        if (w_bit_end) begin
          w_clk_cnt_nxt = 16'd0;
          w_bit_nxt     = 3'd0;
          w_state_nxt   = DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_clk_cnt_nxt = 16'd0;
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
          else                   w_bit_nxt   = r_bit_idx + 3'd1;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_clk_cnt_nxt = 16'd0;
          if (r_byte_idx != 2'd3) begin
            w_byte_nxt  = r_byte_idx + 2'd1;
            w_state_nxt = START;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end
    endcase
    // Line level is derived from the next state so the registered output
    // lines up with the state it belongs to.
    w_serial_nxt = 1'b1;
    if (w_state_nxt == START)     w_serial_nxt = 1'b0;
    else if (w_state_nxt == DATA) w_serial_nxt = r_word[{w_byte_nxt, w_bit_nxt}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_clk_cnt   <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_byte_idx  <= 2'd0;
      r_tx_serial <= 1'b1;
      r_tx_done   <= 1'b0;
      r_word      <= 32'd0;
      r_cpb       <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_idx   <= w_bit_nxt;
      r_byte_idx  <= w_byte_nxt;
      r_tx_serial <= w_serial_nxt;
      r_tx_done   <= w_done_nxt;
      if (w_pop) begin
        r_word <= r_mem[r_rd_ptr];
        r_cpb  <= (clks_per_bit == 16'd0) ? 16'd1 : clks_per_bit;
      end
    end
  end

  assign o_tx_serial  = r_tx_serial;
  assign o_tx_active  = (r_state != IDLE);
  assign o_tx_done    = r_tx_done;
  assign o_fifo_count = r_count;

endmodule

// File: doc/fpu_result_uart_tx.md
FPU_RESULT_UART_TX -- requirements
Module: fpu_result_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of 32-bit result words buffered; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port clks_per_bit  input  16  clk cycles per serial bit (348 in system use).
REQ-005 SHALL have port res_valid  input  1  result word offered this cycle.
REQ-006 SHALL have port res_data  input  32  FPU result word.
REQ-007 SHALL have port res_ready  output  1  FIFO can accept a word (not full).
REQ-008 SHALL have port o_tx_serial  output  1  UART line, 8N1, idle high.
REQ-009 SHALL have port o_tx_active  output  1  high while any frame of a word is on the line.
REQ-010 SHALL have port o_tx_done  output  1  one-cycle pulse after the stop bit of a word's last byte.
REQ-011 SHALL have port o_fifo_count  output  5  words currently held in FIFO (excludes word being sent).

Function
REQ-012 SHALL write res_data into the FIFO on any cycle with res_valid & res_ready; res_valid while full is dropped, FIFO and count unchanged.
REQ-013 SHALL drive res_ready = (o_fifo_count < FIFO_DEPTH), combinational from registered count.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: when FIFO non-empty, pop head into 32-bit shift word, latch clks_per_bit, byte index := 0, go START next cycle; line high in IDLE.
REQ-016 START: o_tx_serial = 0 for one bit time, then DATA with bit index 0.
REQ-017 DATA: send current byte LSB first, one bit time per bit; after bit 7 go STOP.
REQ-018 STOP: o_tx_serial = 1 for one bit time; if byte index < 3, increment and go START (no idle gap); else pulse o_tx_done, go IDLE.
REQ-019 Byte order SHALL be little-endian: res_data[7:0] first, [31:24] last.
REQ-020 Bit time SHALL equal latched clks_per_bit cycles via counter 0..N-1; latched value 0 SHALL be treated as 1; clks_per_bit changes mid-word SHALL not affect that word.
REQ-021 Word duration SHALL be exactly 40*N cycles from first START cycle to o_tx_done pulse cycle (pulse coincides with first cycle back in IDLE).
REQ-022 Back-to-back words: IDLE SHALL last exactly one cycle when FIFO non-empty on entry.
REQ-023 Simultaneous push and pop (including when full) SHALL both take effect; count unchanged.
REQ-024 o_tx_active SHALL be high in START, DATA, STOP; low in IDLE.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 o_tx_serial SHALL be registered (glitch-free).

Reset
REQ-027 On rst high at a clock edge: state IDLE, FIFO empty, pointers 0, o_fifo_count 0, o_tx_serial 1, o_tx_active 0, o_tx_done 0, counters 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately (line high next cycle); FIFO contents discarded.
REQ-029 res_valid during reset SHALL be ignored.

Verification
REQ-030 clks_per_bit=4, push 0x12345678 once -> line decodes 0x78,0x56,0x34,0x12, each 40 cycles, o_tx_done pulse 160 cycles after first START.
REQ-031 FIFO_DEPTH=4, clks_per_bit=2, push 6 consecutive words from reset -> word0 popped, words1-4 fill FIFO, res_ready low, word5 dropped; 5 words transmitted in order.
REQ-032 Full FIFO, push coincident with pop at word boundary -> accepted, count stays 4, order preserved.
REQ-033 clks_per_bit=0, push 0xFFFFFFFF -> 1-cycle bits, 40-cycle word, o_tx_done once.
REQ-034 Assert rst during DATA of byte 2 -> next cycle line 1, active 0, count 0; no o_tx_done.
REQ-035 Change clks_per_bit 4->8 mid-word -> current word stays 4/bit, next word 8/bit.
